dragon_collision_scanner: RTL and testbench

- Consumer of the dragon body segment queue.
- Once per frame, on the vsync rising edge, snapshots the head, the seven body segments, the display enables, the player position and the sword position.
- Scans the segments sequentially, one per clock, and emits single-cycle hit pulses:
  - body_hit drives the body block's shrink (hit) input.
  - player_hit goes to player health logic.

---
 rtl/dragon_collision_scanner.sv | 136 +++++++++++++
 tb/tb_dragon_collision_scanner.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dragon_collision_scanner.sv
// Per-frame sword/player collision scan over the dragon head and seven body segments.
// Optional body_hit cooldown is enabled by defining COLLISION_COOLDOWN_EN.
module dragon_collision_scanner #(
  parameter int PLAYER_CHECK_HEAD = 1,
  parameter int COOLDOWN_FRAMES   = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic [9:0] dragon_head,
  input  logic [9:0] dragon_1,
  input  logic [9:0] dragon_2,
  input  logic [9:0] dragon_3,
  input  logic [9:0] dragon_4,
  input  logic [9:0] dragon_5,
  input  logic [9:0] dragon_6,
  input  logic [9:0] dragon_7,
  input  logic [6:0] display_en,
  input  logic [7:0] player_pos,
  input  logic [7:0] sword_pos,
  input  logic       sword_active,
  output logic       body_hit,
  output logic       player_hit,
  output logic [2:0] hit_index,
  output logic       scan_busy,
  output logic       scan_done,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, REPORT = 2'd2} state_t;

  localparam logic [5:0] COOL_LOAD = 6'(COOLDOWN_FRAMES);

  state_t          state;
  logic            prev_vsync;
  logic [2:0]      idx;
  logic [6:0][7:0] snap_pos;
  logic [6:0]      snap_en;
  logic [7:0]      snap_sword;
  logic [7:0]      snap_player;
  logic            snap_active;
  logic            acc_player;
  logic [2:0]      acc_idx;
  logic            suppress;
  logic            vsync_edge;
  logic [6:0][7:0] seg_pos_in;
  logic            unused_bits;

  // Orientation bits take no part in matching.
  assign seg_pos_in  = {dragon_7[7:0], dragon_6[7:0], dragon_5[7:0], dragon_4[7:0],
                        dragon_3[7:0], dragon_2[7:0], dragon_1[7:0]};
  assign unused_bits = ^{dragon_head[9:8], dragon_1[9:8], dragon_2[9:8], dragon_3[9:8],
                         dragon_4[9:8], dragon_5[9:8], dragon_6[9:8], dragon_7[9:8], COOL_LOAD};
  assign vsync_edge  = vsync && !prev_vsync;
  assign dbg_state   = state;

`ifdef COLLISION_COOLDOWN_EN
  logic [5:0] cool_cnt;
  logic       snap_cool;
  // Suppression is decided by the counter value seen at the frame's accepted edge.
  assign suppress = snap_cool;
`else
  assign suppress = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      prev_vsync  <= 1'b0;
      idx         <= '0;
      snap_pos    <= '0;
      snap_en     <= '0;
      snap_sword  <= '0;
      snap_player <= '0;
      snap_active <= 1'b0;
      acc_player  <= 1'b0;
      acc_idx     <= '0;
      body_hit    <= 1'b0;
      player_hit  <= 1'b0;
      hit_index   <= '0;
      scan_busy   <= 1'b0;
      scan_done   <= 1'b0;
`ifdef COLLISION_COOLDOWN_EN
      cool_cnt    <= '0;
      snap_cool   <= 1'b0;
`endif
    end else begin
      prev_vsync <= vsync;
      body_hit   <= 1'b0;
      player_hit <= 1'b0;
      scan_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (vsync_edge) begin
            snap_pos    <= seg_pos_in;
            snap_en     <= display_en;
            snap_sword  <= sword_pos;
            snap_player <= player_pos;
            snap_active <= sword_active;
            acc_player  <= (PLAYER_CHECK_HEAD != 0) && (dragon_head[7:0] == player_pos);
            acc_idx     <= '0;
            idx         <= '0;
            scan_busy   <= 1'b1;
            state       <= SCAN;
`ifdef COLLISION_COOLDOWN_EN
            snap_cool   <= (cool_cnt != 6'd0);
            if (cool_cnt != 6'd0) cool_cnt <= cool_cnt - 6'd1;
`endif
          end
        end
        SCAN: begin
          // Only the first sword match is recorded; later matches leave it alone.
          if (snap_active && snap_en[idx] && (snap_pos[idx] == snap_sword) && (acc_idx == 3'd0))
            acc_idx <= idx + 3'd1;
          if (snap_en[idx] && (snap_pos[idx] == snap_player))
            acc_player <= 1'b1;
          if (idx == 3'd6) state <= REPORT;
          else             idx   <= idx + 3'd1;
        end
        REPORT: begin
          scan_done  <= 1'b1;
          player_hit <= acc_player;
          body_hit   <= (acc_idx != 3'd0) && !suppress;
          hit_index  <= suppress ? 3'd0 : acc_idx;
          scan_busy  <= 1'b0;
          state      <= IDLE;
`ifdef COLLISION_COOLDOWN_EN
          if ((acc_idx != 3'd0) && !snap_cool) cool_cnt <= COOL_LOAD;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dragon_collision_scanner.sv
// Bench for dragon_collision_scanner: directed vector table, hand-written corner sequences
// and randomized frames against a frame-level reference model.
module tb_dragon_collision_scanner;

  logic            clk;
  logic            reset;
  logic            vsync;
  logic [9:0]      dragon_head;
  logic [6:0][9:0] seg;
  logic [6:0]      display_en;
  logic [7:0]      player_pos;
  logic [7:0]      sword_pos;
  logic            sword_active;

  logic       body_hit, player_hit, scan_busy, scan_done;
  logic [2:0] hit_index;
  logic [1:0] dbg_state;
  logic       nh_body_hit, nh_player_hit, nh_scan_busy, nh_scan_done;
  logic [2:0] nh_hit_index;
  logic [1:0] nh_dbg_state;

  int total = 0;
  int bad   = 0;
  int cool_d = 0;
  int cool_n = 0;

  dragon_collision_scanner dut (
    .clk(clk), .reset(reset), .vsync(vsync), .dragon_head(dragon_head),
    .dragon_1(seg[0]), .dragon_2(seg[1]), .dragon_3(seg[2]), .dragon_4(seg[3]),
    .dragon_5(seg[4]), .dragon_6(seg[5]), .dragon_7(seg[6]),
    .display_en(display_en), .player_pos(player_pos), .sword_pos(sword_pos),
    .sword_active(sword_active), .body_hit(body_hit), .player_hit(player_hit),
    .hit_index(hit_index), .scan_busy(scan_busy), .scan_done(scan_done),
    .dbg_state(dbg_state)
  );

  dragon_collision_scanner #(.PLAYER_CHECK_HEAD(0), .COOLDOWN_FRAMES(2)) dut_nh (
    .clk(clk), .reset(reset), .vsync(vsync), .dragon_head(dragon_head),
    .dragon_1(seg[0]), .dragon_2(seg[1]), .dragon_3(seg[2]), .dragon_4(seg[3]),
    .dragon_5(seg[4]), .dragon_6(seg[5]), .dragon_7(seg[6]),
    .display_en(display_en), .player_pos(player_pos), .sword_pos(sword_pos),
    .sword_active(sword_active), .body_hit(nh_body_hit), .player_hit(nh_player_hit),
    .hit_index(nh_hit_index), .scan_busy(nh_scan_busy), .scan_done(nh_scan_done),
    .dbg_state(nh_dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [6:0]      en;
    logic [6:0][9:0] seg;
    logic [9:0]      head;
    logic [7:0]      player;
    logic [7:0]      sword;
    logic            active;
    logic            exp_body;
    logic            exp_player;
    logic            exp_player_nh;
    logic [2:0]      exp_idx;
  } vec_t;

  typedef struct {
    logic [15:0] bh, ph, nbh, nph, dn, busy;
    logic [2:0]  idx8, nidx8, idx15;
  } cap_t;

  localparam int W = 10;
  logic [W-1:0] exp_q[$];
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    vsync = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    cool_d = 0;
    cool_n = 0;
  endtask

  // Driver tasks
  task automatic apply_vec(input vec_t v);
    display_en   = v.en;
    seg          = v.seg;
    dragon_head  = v.head;
    player_pos   = v.player;
    sword_pos    = v.sword;
    sword_active = v.active;
  endtask

  task automatic rand_inputs();
    display_en = 7'($urandom);
    for (int i = 0; i < 7; i++) seg[i] = {2'($urandom), 8'($urandom_range(0, 7))};
    dragon_head  = {2'($urandom), 8'($urandom_range(0, 7))};
    player_pos   = 8'($urandom_range(0, 7));
    sword_pos    = 8'($urandom_range(0, 7));
    sword_active = ($urandom_range(0, 3) != 0);
  endtask

  function automatic vec_t cur_stim();
    vec_t v;
    v.en = display_en; v.seg = seg; v.head = dragon_head;
    v.player = player_pos; v.sword = sword_pos; v.active = sword_active;
    v.exp_body = 1'b0; v.exp_player = 1'b0; v.exp_player_nh = 1'b0; v.exp_idx = 3'd0;
    return v;
  endfunction

  // mode 0: quiet; 1: randomize all inputs mid-scan + second edge; 2: move dragon_1 mid-scan + second edge
  task automatic run_frame(input int mode, output cap_t c);
    @(negedge clk);
    vsync = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
      c.bh[k] = body_hit;     c.ph[k] = player_hit;
      c.nbh[k] = nh_body_hit; c.nph[k] = nh_player_hit;
      c.dn[k] = scan_done;    c.busy[k] = scan_busy;
      if (k == 8)  begin c.idx8 = hit_index; c.nidx8 = nh_hit_index; end
      if (k == 15) c.idx15 = hit_index;
      if (k == 0) vsync = 1'b0;
      if (k == 2 && mode == 1) rand_inputs();
      if (k == 2 && mode == 2) seg[0] = 10'h099;
      if (k == 3 && mode != 0) vsync = 1'b1;
      if (k == 4 && mode != 0) vsync = 1'b0;
    end
  endtask

  // Reference model: frame result straight from the matching rules.
  function automatic logic [4:0] model(input vec_t v, input bit check_head);
    logic [2:0] first;
    logic       pl;
    first = 3'd0;
    pl = check_head && (v.head[7:0] == v.player);
    for (int i = 0; i < 7; i++) begin
      if (v.en[i] && v.seg[i][7:0] == v.player) pl = 1'b1;
      if (v.active && v.en[i] && v.seg[i][7:0] == v.sword && first == 3'd0) first = 3'(i + 1);
    end
    return {first != 3'd0, pl, first};
  endfunction

  task automatic cool_apply(input int n, inout int cnt, inout logic [4:0] r);
    bit sup;
    sup = (cnt != 0);
    if (cnt > 0) cnt--;
    if (sup) r = {1'b0, r[3], 3'd0};
    else if (r[4]) cnt = n;
  endtask

  function automatic vec_t mk(input logic [6:0] en, input logic [9:0] head, input logic [7:0] player,
                              input logic [7:0] sword, input logic active, input logic eb,
                              input logic ep, input logic epn, input logic [2:0] ei);
    vec_t v;
    for (int i = 0; i < 7; i++) v.seg[i] = {2'(i), 8'hF0};
    v.en = en; v.head = head; v.player = player; v.sword = sword; v.active = active;
    v.exp_body = eb; v.exp_player = ep; v.exp_player_nh = epn; v.exp_idx = ei;
    return v;
  endfunction

  initial begin
    cap_t c;
    vec_t v;
    logic [4:0] rd, rn;
    logic [W-1:0] e;
    bit exp_d, exp_n;

    reset = 1'b1; vsync = 1'b0;
    v = mk(7'd0, 10'h0FF, 8'hEE, 8'h77, 1'b0, 0, 0, 0, 3'd0);
    apply_vec(v);
    do_reset();
    #1;
    check("reset body_hit", body_hit, 0);
    check("reset player_hit", player_hit, 0);
    check("reset hit_index", hit_index, 0);
    check("reset scan_done", scan_done, 0);
    check("reset scan_busy", scan_busy, 0);

    // Directed vector table
    vecs[0] = mk(7'b0000001, 10'h0FF, 8'hEE, 8'h45, 1'b1, 1, 0, 0, 3'd1);
    vecs[0].seg[0] = 10'h045;
    vecs[1] = mk(7'b0000111, 10'h0FF, 8'hEE, 8'h33, 1'b1, 1, 0, 0, 3'd2);
    vecs[1].seg[0] = 10'h011; vecs[1].seg[1] = 10'h033; vecs[1].seg[2] = 10'h233;
    vecs[2] = vecs[1]; vecs[2].en = 7'b0000011;
    vecs[3] = vecs[1]; vecs[3].en = 7'b0000000; vecs[3].exp_body = 0; vecs[3].exp_idx = 3'd0;
    vecs[4] = mk(7'b0000001, 10'h0FF, 8'hEE, 8'h45, 1'b0, 0, 0, 0, 3'd0);
    vecs[4].seg[0] = 10'h045;
    vecs[5] = mk(7'b0000000, 10'h310, 8'h10, 8'h77, 1'b1, 0, 1, 0, 3'd0);
    vecs[6] = mk(7'b1111111, 10'h000, 8'hA0, 8'h5C, 1'b1, 1, 1, 1, 3'd7);
    vecs[6].seg[4] = 10'h1A0; vecs[6].seg[6] = 10'h05C;
    vecs[7] = mk(7'b0000100, 10'h055, 8'h00, 8'h00, 1'b1, 1, 1, 1, 3'd3);
    for (int i = 0; i < 7; i++) vecs[7].seg[i] = 10'h000;
    vecs[8] = mk(7'b1111110, 10'h0FF, 8'hAB, 8'hAB, 1'b1, 0, 0, 0, 3'd0);
    vecs[8].seg[0] = 10'h0AB;
    vecs[9] = mk(7'b0001000, 10'h0FF, 8'hEE, 8'hC4, 1'b1, 1, 0, 0, 3'd4);
    vecs[9].seg[3] = 10'h3C4;

    for (int n = 0; n < 10; n++) begin
      do_reset();
      apply_vec(vecs[n]);
      run_frame(0, c);
      check($sformatf("vec%0d body_hit", n), c.bh, vecs[n].exp_body ? 16'h0100 : 16'h0);
      check($sformatf("vec%0d player_hit", n), c.ph, vecs[n].exp_player ? 16'h0100 : 16'h0);
      check($sformatf("vec%0d player_hit nohead", n), c.nph, vecs[n].exp_player_nh ? 16'h0100 : 16'h0);
      check($sformatf("vec%0d scan_done", n), c.dn, 16'h0100);
      check($sformatf("vec%0d scan_busy", n), c.busy, 16'h00FF);
      check($sformatf("vec%0d hit_index", n), c.idx8, vecs[n].exp_idx);
      check($sformatf("vec%0d hit_index held", n), c.idx15, vecs[n].exp_idx);
    end

    // Second edge mid-scan ignored; dragon_1 moved mid-scan keeps the snapshot result
    do_reset();
    apply_vec(vecs[0]);
    run_frame(2, c);
    check("midscan scan_done", c.dn, 16'h0100);
    check("midscan body_hit", c.bh, 16'h0100);
    check("midscan hit_index", c.idx8, 3'd1);

    // Reset during SCAN cycle 4
    do_reset();
    apply_vec(vecs[6]);
    @(negedge clk);
    vsync = 1'b1;
    @(posedge clk); #1; vsync = 1'b0;
    repeat (3) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    cool_d = 0; cool_n = 0;
    check("rst-mid scan_busy", scan_busy, 0);
    c.bh = '0; c.ph = '0; c.dn = '0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      c.bh[k] = body_hit; c.ph[k] = player_hit; c.dn[k] = scan_done;
    end
    check("rst-mid body_hit", c.bh, 16'h0);
    check("rst-mid player_hit", c.ph, 16'h0);
    check("rst-mid scan_done", c.dn, 16'h0);
    run_frame(0, c);
    check("after rst body_hit", c.bh, 16'h0100);
    check("after rst player_hit", c.ph, 16'h0100);
    check("after rst hit_index", c.idx8, 3'd7);

    // Persistent sword overlap over five frames
    do_reset();
    apply_vec(vecs[0]);
    for (int f = 0; f < 5; f++) begin
`ifdef COLLISION_COOLDOWN_EN
      exp_d = (f == 0);
      exp_n = (f == 0) || (f == 3);
`else
      exp_d = 1'b1;
      exp_n = 1'b1;
`endif
      run_frame(0, c);
      check($sformatf("persist f%0d body_hit", f + 1), c.bh, exp_d ? 16'h0100 : 16'h0);
      check($sformatf("persist f%0d body_hit cd2", f + 1), c.nbh, exp_n ? 16'h0100 : 16'h0);
    end

    // Randomized frames against the reference model (scoreboard)
    do_reset();
    for (int f = 0; f < 40; f++) begin
      rand_inputs();
      v  = cur_stim();
      rd = model(v, 1'b1);
      rn = model(v, 1'b0);
`ifdef COLLISION_COOLDOWN_EN
      cool_apply(30, cool_d, rd);
      cool_apply(2, cool_n, rn);
`endif
      exp_q.push_back({rd, rn});
      run_frame($urandom_range(0, 1), c);
      e = exp_q.pop_front();
      check($sformatf("rand%0d body_hit", f), c.bh, e[9] ? 16'h0100 : 16'h0);
      check($sformatf("rand%0d player_hit", f), c.ph, e[8] ? 16'h0100 : 16'h0);
      check($sformatf("rand%0d hit_index", f), c.idx8, e[7:5]);
      check($sformatf("rand%0d nh body_hit", f), c.nbh, e[4] ? 16'h0100 : 16'h0);
      check($sformatf("rand%0d nh player_hit", f), c.nph, e[3] ? 16'h0100 : 16'h0);
      check($sformatf("rand%0d nh hit_index", f), c.nidx8, e[2:0]);
      check($sformatf("rand%0d scan_done", f), c.dn, 16'h0100);
    end

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
